// File: rtl/ysyx_24100005_lsu_pkg.sv
// Shared types and constants for the load/store unit.
// State encoding, RISC-V funct3 width codes and the default WAIT budget.
package ysyx_24100005_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;

    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;
    localparam logic [2:0] SD = 3'b011;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/ysyx_24100005_lsu_if.sv
// Core request/response and memory bus bundle around the LSU.
// slave is the LSU view, master is the core+memory environment view.
interface ysyx_24100005_lsu_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    localparam int MASK_W = XLEN / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [XLEN-1:0]   req_wdata;
    logic              rsp_valid;
    logic [XLEN-1:0]   rsp_rdata;
    logic              rsp_err;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wmask
    );

endinterface

// File: rtl/ysyx_24100005_lsu_align.sv
// Byte-lane logic: legality check, store lane placement and
// load extraction with sign/zero extension.
module ysyx_24100005_lsu_align
    import ysyx_24100005_lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int MASK_W = XLEN / 8,
    localparam int OFF_W = $clog2(MASK_W)
) (
    input  logic              we,
    input  logic [2:0]        funct3,
    input  logic [2:0]        lo,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic              fault,
    output logic [XLEN-1:0]   wdata_lane,
    output logic [MASK_W-1:0] wmask,
    output logic [XLEN-1:0]   rdata_ext
);

    logic [OFF_W-1:0] off;
    logic [XLEN-1:0]  sh;
    logic [7:0]       size_mask;
    logic             misal;
    logic             illegal;

    assign off        = lo[OFF_W-1:0];
    assign sh         = rdata >> {off, 3'b000};
    assign wdata_lane = wdata << {off, 3'b000};
    assign wmask      = MASK_W'(size_mask) << off;
    assign fault      = misal | illegal;

    always_comb begin
        size_mask = 8'h01;
        misal     = 1'b0;
        unique case (funct3[1:0])
            2'b00: begin
                size_mask = 8'h01;
                misal     = 1'b0;
            end
            2'b01: begin
                size_mask = 8'h03;
                misal     = lo[0];
            end
            2'b10: begin
                size_mask = 8'h0F;
                misal     = |lo[1:0];
            end
            default: begin
                size_mask = 8'hFF;
                misal     = |lo;
            end
        endcase
    end

    // RV32 has no ld/lwu/sd; funct3=111 is never a memory op
    always_comb begin
        illegal = (funct3 == 3'b111);
        if (we) begin
            illegal = (XLEN == 32) ? (funct3 > SW) : (funct3 > SD);
        end else if (XLEN == 32 && (funct3 == LD || funct3 == LWU)) begin
            illegal = 1'b1;
        end
    end

    always_comb begin
        rdata_ext = sh;
        unique case (funct3)
            LB:      rdata_ext = XLEN'($signed(sh[7:0]));
            LH:      rdata_ext = XLEN'($signed(sh[15:0]));
            LW:      rdata_ext = XLEN'($signed(sh[31:0]));
            LBU:     rdata_ext = XLEN'(sh[7:0]);
            LHU:     rdata_ext = XLEN'(sh[15:0]);
            LWU:     rdata_ext = XLEN'(sh[31:0]);
            default: rdata_ext = sh;
        endcase
    end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Single-outstanding load/store unit: IDLE -> ISSUE -> WAIT -> RESP,
// with faults short-circuiting straight to RESP.
module ysyx_24100005_lsu
    import ysyx_24100005_lsu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int MASK_W = XLEN / 8,
    localparam int OFF_W  = $clog2(MASK_W)
) (
    input logic clk,
    input logic rst,
    ysyx_24100005_lsu_if.slave bus
);

    state_e            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              idle, issue, accept;
    logic              a_we;
    logic [2:0]        a_f3;
    logic [2:0]        a_lo;
    logic              fault;
    logic [XLEN-1:0]   wlane, rext;
    logic [MASK_W-1:0] wmask;

    assign idle   = (state_q == IDLE);
    assign issue  = (state_q == ISSUE);
    assign accept = idle & bus.req_valid;

    // fault is judged on the live request; lanes use the latched copy
    assign a_we = idle ? bus.req_we : we_q;
    assign a_f3 = idle ? bus.req_funct3 : f3_q;
    assign a_lo = idle ? bus.req_addr[2:0] : addr_q[2:0];

    ysyx_24100005_lsu_align #(.XLEN(XLEN)) u_align (
        .we         (a_we),
        .funct3     (a_f3),
        .lo         (a_lo),
        .wdata      (wdata_q),
        .rdata      (bus.mem_rdata),
        .fault      (fault),
        .wdata_lane (wlane),
        .wmask      (wmask),
        .rdata_ext  (rext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    cnt_d = '0;
                    if (fault) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.mem_req_ready) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (bus.mem_rsp_valid) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : rext;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready     = idle;
    assign bus.rsp_valid     = (state_q == RESP);
    assign bus.rsp_rdata     = rdata_q;
    assign bus.rsp_err       = err_q;
    assign bus.mem_req_valid = issue;
    assign bus.mem_we        = issue & we_q;
    assign bus.mem_addr      = issue ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    assign bus.mem_wdata     = (issue & we_q) ? wlane : '0;
    assign bus.mem_wmask     = (issue & we_q) ? wmask : '0;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Scoreboarded bench for the LSU: a reactive memory model answers
// requests, expected responses are queued at issue and popped at rsp_valid.
module tb_ysyx_24100005_lsu;
    import ysyx_24100005_lsu_pkg::*;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] word;
        logic [31:0] exp;
    } ld_t;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
    } ft_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] maddr;
        logic [3:0]  mask;
        logic [31:0] mwd;
    } st_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_24100005_lsu_if #(.XLEN(32), .ADDR_W(32)) bus ();

    ysyx_24100005_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   vec  = 0;
    int   errs = 0;

    logic [31:0] mem_word;
    bit          silent;
    bit          early;
    int          stall_cfg;
    int          late_cnt;
    int          late_seen = 0;
    int          stall_run = 0;
    bit          rsp_due   = 1'b0;

    // memory model: optional stall, optional early (ignored) response,
    // otherwise answers in the first cycle after the handshake
    always @(negedge clk) begin
        bus.mem_rsp_valid = 1'b0;
        if (rsp_due || late_seen != late_cnt) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rdata     = mem_word;
            rsp_due           = 1'b0;
            late_seen         = late_cnt;
        end
        if (bus.mem_req_valid === 1'b1) begin
            if (stall_run < stall_cfg) begin
                bus.mem_req_ready = 1'b0;
                stall_run++;
            end else begin
                bus.mem_req_ready = 1'b1;
                if (early) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rdata     = ~mem_word;
                end
                rsp_due = !silent;
            end
        end else begin
            bus.mem_req_ready = 1'b0;
            stall_run         = 0;
        end
    end

    task automatic send(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_we     = ~we;
        bus.req_funct3 = 3'b111;
        bus.req_addr   = ~a;
        bus.req_wdata  = ~wd;
    endtask

    task automatic wait_rsp(input int first, output int lat, output bit got);
        lat = first;
        while (bus.rsp_valid !== 1'b1 && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        got = (bus.rsp_valid === 1'b1);
    endtask

    task automatic test_reset;
        vec++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_req_valid, bus.mem_we} !== 5'b10000) begin
            errs++;
            $display("FAIL reset_ctrl: got %b want 10000",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_err, bus.mem_req_valid, bus.mem_we});
        end
        vec++;
        if ({bus.rsp_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wmask} !== 100'd0) begin
            errs++;
            $display("FAIL reset_data: rdata %h addr %h wdata %h mask %h want all 0",
                     bus.rsp_rdata, bus.mem_addr, bus.mem_wdata, bus.mem_wmask);
        end
    endtask

    task automatic test_loads;
        ld_t  t[9] = '{
            '{LB,  32'h8000_0003, 32'h80FF_1234, 32'hFFFF_FF80},
            '{LBU, 32'h8000_0003, 32'h80FF_1234, 32'h0000_0080},
            '{LB,  32'h8000_0002, 32'h80FF_1234, 32'hFFFF_FFFF},
            '{LBU, 32'h8000_0001, 32'h80FF_1234, 32'h0000_0012},
            '{LH,  32'h8000_0002, 32'h80FF_1234, 32'hFFFF_80FF},
            '{LHU, 32'h8000_0002, 32'h80FF_1234, 32'h0000_80FF},
            '{LH,  32'h8000_0000, 32'h80FF_1234, 32'h0000_1234},
            '{LW,  32'h8000_0004, 32'h80FF_1234, 32'h80FF_1234},
            '{LB,  32'h8000_0000, 32'h0000_007F, 32'h0000_007F}
        };
        exp_t e;
        int   lat;
        bit   got;
        for (int i = 0; i < 9; i++) begin
            mem_word = t[i].word;
            sb.push_back('{1'b0, t[i].exp, 3});
            send(1'b0, t[i].f3, t[i].addr, 32'hDEAD_BEEF);
            wait_rsp(1, lat, got);
            e = sb.pop_front();
            vec++;
            if (!got || lat != e.lat) begin
                errs++;
                $display("FAIL load[%0d] latency: got %0d want %0d", i, lat, e.lat);
            end
            vec++;
            if ({bus.rsp_err, bus.rsp_rdata} !== {e.err, e.rdata}) begin
                errs++;
                $display("FAIL load[%0d] rsp: got err=%b rdata=%h want err=%b rdata=%h",
                         i, bus.rsp_err, bus.rsp_rdata, e.err, e.rdata);
            end
            @(negedge clk);
            vec++;
            if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== e.rdata) begin
                errs++;
                $display("FAIL load[%0d] pulse/hold: got valid=%b rdata=%h want valid=0 rdata=%h",
                         i, bus.rsp_valid, bus.rsp_rdata, e.rdata);
            end
        end
    endtask

    task automatic test_faults;
        ft_t  t[9] = '{
            '{1'b0, LW,     32'h8000_0001},
            '{1'b0, LH,     32'h8000_0003},
            '{1'b0, 3'b111, 32'h8000_0000},
            '{1'b0, LD,     32'h8000_0000},
            '{1'b0, LWU,    32'h8000_0000},
            '{1'b1, SD,     32'h8000_0000},
            '{1'b1, 3'b100, 32'h8000_0000},
            '{1'b1, SW,     32'h8000_0002},
            '{1'b1, SH,     32'h8000_0001}
        };
        exp_t e;
        int   lat;
        bit   got;
        mem_word = 32'h1234_5678;
        for (int i = 0; i < 9; i++) begin
            sb.push_back('{1'b1, 32'h0, 1});
            send(t[i].we, t[i].f3, t[i].addr, 32'h5555_AAAA);
            vec++;
            if (bus.mem_req_valid !== 1'b0) begin
                errs++;
                $display("FAIL fault[%0d] mem_req_valid: got %b want 0", i, bus.mem_req_valid);
            end
            wait_rsp(1, lat, got);
            e = sb.pop_front();
            vec++;
            if (!got || lat != e.lat || {bus.rsp_err, bus.rsp_rdata} !== {e.err, e.rdata}) begin
                errs++;
                $display("FAIL fault[%0d] rsp: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                         i, lat, bus.rsp_err, bus.rsp_rdata, e.lat, e.err, e.rdata);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stores;
        st_t  t[5] = '{
            '{SH, 32'h8000_0002, 32'h0000_BEEF, 32'h8000_0000, 4'hC, 32'hBEEF_0000},
            '{SB, 32'h8000_0001, 32'h1234_56A5, 32'h8000_0000, 4'h2, 32'h3456_A500},
            '{SW, 32'h8000_0004, 32'hCAFE_F00D, 32'h8000_0004, 4'hF, 32'hCAFE_F00D},
            '{SB, 32'h8000_0007, 32'h0000_00EE, 32'h8000_0004, 4'h8, 32'hEE00_0000},
            '{SH, 32'h8000_0000, 32'hABCD_1234, 32'h8000_0000, 4'h3, 32'hABCD_1234}
        };
        exp_t e;
        int   lat;
        bit   got;
        mem_word = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{1'b0, 32'h0, 3});
            send(1'b1, t[i].f3, t[i].addr, t[i].wd);
            vec++;
            if ({bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wmask, bus.mem_wdata}
                !== {2'b11, t[i].maddr, t[i].mask, t[i].mwd}) begin
                errs++;
                $display("FAIL store[%0d] bus: got v=%b we=%b addr=%h mask=%h wdata=%h want v=1 we=1 addr=%h mask=%h wdata=%h",
                         i, bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wmask, bus.mem_wdata,
                         t[i].maddr, t[i].mask, t[i].mwd);
            end
            wait_rsp(1, lat, got);
            e = sb.pop_front();
            vec++;
            if (!got || lat != e.lat || {bus.rsp_err, bus.rsp_rdata} !== {e.err, e.rdata}) begin
                errs++;
                $display("FAIL store[%0d] rsp: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                         i, lat, bus.rsp_err, bus.rsp_rdata, e.lat, e.err, e.rdata);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall;
        exp_t e;
        int   lat;
        bit   got;
        mem_word  = 32'h80FF_1234;
        stall_cfg = 4;
        sb.push_back('{1'b0, 32'h0000_1234, 7});
        send(1'b0, LHU, 32'h8000_0000, 32'h0);
        for (int i = 0; i < 4; i++) begin
            vec++;
            if ({bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wmask} !== {2'b10, 32'h8000_0000, 4'h0}) begin
                errs++;
                $display("FAIL stall[%0d] bus: got v=%b we=%b addr=%h mask=%h want v=1 we=0 addr=80000000 mask=0",
                         i, bus.mem_req_valid, bus.mem_we, bus.mem_addr, bus.mem_wmask);
            end
            @(negedge clk);
        end
        wait_rsp(5, lat, got);
        e = sb.pop_front();
        vec++;
        if (!got || lat != e.lat || {bus.rsp_err, bus.rsp_rdata} !== {e.err, e.rdata}) begin
            errs++;
            $display("FAIL stall rsp: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                     lat, bus.rsp_err, bus.rsp_rdata, e.lat, e.err, e.rdata);
        end
        stall_cfg = 0;
        @(negedge clk);
    endtask

    task automatic test_early;
        exp_t e;
        int   lat;
        bit   got;
        mem_word = 32'h1357_9BDF;
        early    = 1'b1;
        sb.push_back('{1'b0, 32'h1357_9BDF, 3});
        send(1'b0, LW, 32'h8000_0008, 32'h0);
        wait_rsp(1, lat, got);
        e = sb.pop_front();
        vec++;
        if (!got || lat != e.lat || {bus.rsp_err, bus.rsp_rdata} !== {e.err, e.rdata}) begin
            errs++;
            $display("FAIL early rsp: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                     lat, bus.rsp_err, bus.rsp_rdata, e.lat, e.err, e.rdata);
        end
        early = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_timeout;
        exp_t e;
        int   lat;
        bit   got;
        silent = 1'b1;
        sb.push_back('{1'b1, 32'h0, 10});
        send(1'b0, LW, 32'h8000_0000, 32'h0);
        wait_rsp(1, lat, got);
        e = sb.pop_front();
        vec++;
        if (!got || lat != e.lat || {bus.rsp_err, bus.rsp_rdata} !== {e.err, e.rdata}) begin
            errs++;
            $display("FAIL timeout rsp: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                     lat, bus.rsp_err, bus.rsp_rdata, e.lat, e.err, e.rdata);
        end
        silent = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_inflight;
        exp_t e;
        int   lat;
        bit   got;
        int   seen;
        silent   = 1'b1;
        mem_word = 32'h80FF_1234;
        send(1'b0, LW, 32'h8000_0000, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        vec++;
        if ({bus.req_ready, bus.mem_req_valid, bus.rsp_valid, bus.rsp_err} !== 4'b1000) begin
            errs++;
            $display("FAIL rst_async: got ready=%b mreq=%b valid=%b err=%b want 1 0 0 0",
                     bus.req_ready, bus.mem_req_valid, bus.rsp_valid, bus.rsp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        late_cnt++;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen++;
        end
        vec++;
        if (seen != 0 || bus.req_ready !== 1'b1) begin
            errs++;
            $display("FAIL rst_abandon: got %0d rsp pulses ready=%b want 0 pulses ready=1",
                     seen, bus.req_ready);
        end
        silent = 1'b0;
        sb.push_back('{1'b0, 32'hFFFF_FF80, 3});
        send(1'b0, LB, 32'h8000_0003, 32'h0);
        wait_rsp(1, lat, got);
        e = sb.pop_front();
        vec++;
        if (!got || lat != e.lat || {bus.rsp_err, bus.rsp_rdata} !== {e.err, e.rdata}) begin
            errs++;
            $display("FAIL rst_next rsp: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                     lat, bus.rsp_err, bus.rsp_rdata, e.lat, e.err, e.rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   lat;
        bit   got;
        mem_word = 32'h80FF_1234;
        sb.push_back('{1'b1, 32'h0, 1});
        sb.push_back('{1'b0, 32'h0000_1234, 3});
        for (int i = 0; i < 2; i++) begin
            if (i == 0) send(1'b0, LW, 32'h8000_0002, 32'h0);
            else        send(1'b0, LHU, 32'h8000_0000, 32'h0);
            wait_rsp(1, lat, got);
            e = sb.pop_front();
            vec++;
            if (!got || lat != e.lat || {bus.rsp_err, bus.rsp_rdata} !== {e.err, e.rdata}) begin
                errs++;
                $display("FAIL b2b[%0d] rsp: got lat=%0d err=%b rdata=%h want lat=%0d err=%b rdata=%h",
                         i, lat, bus.rsp_err, bus.rsp_rdata, e.lat, e.err, e.rdata);
            end
            @(negedge clk);
            vec++;
            if (bus.req_ready !== 1'b1) begin
                errs++;
                $display("FAIL b2b[%0d] ready: got %b want 1", i, bus.req_ready);
            end
        end
        vec++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        mem_word       = '0;
        silent         = 1'b0;
        early          = 1'b0;
        stall_cfg      = 0;
        late_cnt       = 0;
        repeat (2) @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_loads;
        test_faults;
        test_stores;
        test_stall;
        test_early;
        test_timeout;
        test_reset_inflight;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/ysyx_24100005_lsu.md
YSYX_24100005_LSU -- requirements
Module: ysyx_24100005_lsu

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before an error response; legal range 1..65535.
REQ-004 SHALL define MASK_W = XLEN/8 and OFF_W = log2(MASK_W), both derived and not overridable.
REQ-005 SHALL have ports:
  clk  input  1  single clock, rising edge
  rst  input  1  reset, asynchronous, active-high
  req_valid  input  1  core request valid
  req_ready  output  1  LSU can accept a request
  req_we  input  1  1 = store, 0 = load
  req_funct3  input  3  RISC-V width/sign code
  req_addr  input  ADDR_W  byte address
  req_wdata  input  XLEN  store data, LSB-aligned
  rsp_valid  output  1  one-cycle completion pulse
  rsp_rdata  output  XLEN  extended load result
  rsp_err  output  1  misaligned, illegal or timeout
  mem_req_valid  output  1  memory request
  mem_req_ready  input  1  memory accepts request
  mem_we  output  1  memory write
  mem_addr  output  ADDR_W  lane-aligned address
  mem_wdata  output  XLEN  lane-positioned write data
  mem_wmask  output  MASK_W  byte enables
  mem_rsp_valid  input  1  memory read data or write ack
  mem_rdata  input  XLEN  full-lane read data

Function
REQ-006 SHALL implement the FSM IDLE, ISSUE, WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-007 SHALL accept a request on req_valid && req_ready and latch all req_* fields; later req_* changes SHALL have no effect.
REQ-008 SHALL treat the following as faults: half access with addr[0]!=0; word access with addr[1:0]!=0; double access with addr[2:0]!=0; funct3=111; loads 011 or 110 when XLEN=32; store funct3>010 when XLEN=32 or >011 when XLEN=64.
REQ-009 On a fault, SHALL go IDLE->RESP without asserting mem_req_valid, then drive rsp_err=1 and rsp_rdata=0.
REQ-010 On a legal request, SHALL go IDLE->ISSUE and hold mem_req_valid=1 with mem_* stable until mem_req_ready=1, then go to WAIT.
REQ-011 mem_addr SHALL equal the latched address with its low OFF_W bits cleared.
REQ-012 For stores, mem_wdata SHALL equal the store data shifted left by offset*8, and mem_wmask SHALL be the size mask (1/3/F/FF) shifted left by offset.
REQ-013 For loads, mem_wmask SHALL be 0.
REQ-014 In WAIT, SHALL count cycles; mem_rsp_valid SHALL capture the result and go to RESP with rsp_err=0.
REQ-015 If the WAIT count reaches TIMEOUT without mem_rsp_valid, SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-016 Load extraction SHALL shift mem_rdata right by offset*8.
REQ-017 lb/lh/lw SHALL sign-extend to XLEN; lbu/lhu/lwu SHALL zero-extend; ld SHALL pass through unchanged.
REQ-018 Store responses SHALL return rsp_rdata=0.
REQ-019 rsp_valid SHALL be high exactly one cycle, in RESP; RESP->IDLE SHALL be unconditional.
REQ-020 rsp_rdata and rsp_err SHALL hold their value until the next RESP.
REQ-021 mem_rsp_valid SHALL be ignored outside WAIT, including when it arrives in the same cycle that mem_req_ready is sampled in ISSUE.
REQ-022 Latency SHALL be:
  - fault: rsp_valid in the cycle after acceptance;
  - zero-wait memory (mem_req_ready=1, mem_rsp_valid in the first WAIT cycle): rsp_valid 3 cycles after acceptance.

Reset
REQ-023 rst=1 SHALL immediately force IDLE, clear the WAIT counter and drive all outputs to 0 except req_ready=1.
REQ-024 An in-flight transaction interrupted by reset SHALL be abandoned without a response; a late mem_rsp_valid SHALL be ignored.

Structure
REQ-025 Package ysyx_24100005_lsu_pkg SHALL hold the state enum, funct3 constants (LB..LWU, LD, SB..SD) and the default TIMEOUT.
REQ-026 Combinational lane logic (extraction, sign/zero extension, mask and wdata generation) SHALL be a sub-module ysyx_24100005_lsu_align.

Verification
REQ-027 lb at 0x80000003, mem_rdata=0x80FF1234, zero-wait memory -> rsp_rdata=0xFFFFFF80, rsp_err=0, rsp_valid 3 cycles after acceptance.
REQ-028 sh at 0x80000002 with wdata 0x0000BEEF -> mem_addr=0x80000000, mem_wmask=0xC, mem_wdata=0xBEEF0000, mem_we=1.
REQ-029 lw at 0x80000001 -> no mem_req_valid, rsp_err=1 and rsp_valid in the cycle after acceptance.
REQ-030 lhu at 0x80000000 with mem_req_ready held low 4 cycles -> mem_* stable for those 4 cycles, then rsp_rdata=0x00001234.
REQ-031 TIMEOUT=8 and mem_rsp_valid never asserted -> rsp_err=1 exactly 8 WAIT cycles after issue acceptance.
REQ-032 rst asserted in WAIT, then mem_rsp_valid -> rsp_valid stays 0, req_ready=1, next request proceeds normally.
